// File: rtl/mem_port_scheduler.sv
// Arbitrates an instruction port and a data port onto one line-wide memory port.
// Optional macro MEM_PORT_SCHED_RR_EN turns the I/D tie-break into round-robin (default: D wins ties).
module mem_port_scheduler (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_read,
  input  logic [31:0]  i_address,
  output logic         i_resp,
  output logic [255:0] i_rdata,
  input  logic         d_read,
  input  logic         d_write,
  input  logic [31:0]  d_address,
  input  logic [255:0] d_wdata,
  output logic         d_resp,
  output logic [255:0] d_rdata,
  output logic         m_read,
  output logic         m_write,
  output logic [31:0]  m_address,
  output logic [255:0] m_wdata,
  input  logic         m_resp,
  input  logic [255:0] m_rdata,
  output logic         busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic           owner_q, owner_d;     // 1'b1 = D side, 1'b0 = I side
  logic [31:0]    addr_q, addr_d;
  logic           wr_q, wr_d;
  logic [255:0]   wdata_q, wdata_d;
  logic [255:0]   buf_q, buf_d;
  logic           m_read_q, m_read_d;
  logic           m_write_q, m_write_d;
  logic           i_resp_q, i_resp_d;
  logic           d_resp_q, d_resp_d;
  logic           busy_q, busy_d;
  logic           d_req_s;
  logic           win_d_s;

  assign d_req_s = d_read | d_write;

`ifdef MEM_PORT_SCHED_RR_EN
  logic           ptr_q, ptr_d;         // 1'b1 = D holds the tie-break
  assign win_d_s = d_req_s & (~i_read | ptr_q);
`else
  assign win_d_s = d_req_s;
`endif

  // Next-state and next-output computation for the grant/serve/respond sequence
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    addr_d    = addr_q;
    wr_d      = wr_q;
    wdata_d   = wdata_q;
    buf_d     = buf_q;
    m_read_d  = 1'b0;
    m_write_d = 1'b0;
    i_resp_d  = 1'b0;
    d_resp_d  = 1'b0;
`ifdef MEM_PORT_SCHED_RR_EN
    ptr_d     = ptr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (i_read | d_req_s) begin
          owner_d   = win_d_s;
          addr_d    = win_d_s ? d_address : i_address;
          wr_d      = win_d_s & d_write;   // write beats read when both are up
          wdata_d   = win_d_s ? d_wdata : 256'd0;
          m_read_d  = ~(win_d_s & d_write);
          m_write_d = win_d_s & d_write;
          state_d   = ST_SERVE;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_SERVE: begin
        if (m_resp) begin
          buf_d    = m_rdata;
          i_resp_d = ~owner_q;
          d_resp_d = owner_q;
          state_d  = ST_RESP;
`ifdef MEM_PORT_SCHED_RR_EN
          ptr_d    = ~ptr_q;
`endif
        end else begin
          m_read_d  = ~wr_q;
          m_write_d = wr_q;
          state_d   = ST_SERVE;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State, latched transaction and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      owner_q   <= 1'b1;
      addr_q    <= 32'd0;
      wr_q      <= 1'b0;
      wdata_q   <= 256'd0;
      buf_q     <= 256'd0;
      m_read_q  <= 1'b0;
      m_write_q <= 1'b0;
      i_resp_q  <= 1'b0;
      d_resp_q  <= 1'b0;
      busy_q    <= 1'b0;
`ifdef MEM_PORT_SCHED_RR_EN
      ptr_q     <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      addr_q    <= addr_d;
      wr_q      <= wr_d;
      wdata_q   <= wdata_d;
      buf_q     <= buf_d;
      m_read_q  <= m_read_d;
      m_write_q <= m_write_d;
      i_resp_q  <= i_resp_d;
      d_resp_q  <= d_resp_d;
      busy_q    <= busy_d;
`ifdef MEM_PORT_SCHED_RR_EN
      ptr_q     <= ptr_d;
`endif
    end
  end

  assign m_read    = m_read_q;
  assign m_write   = m_write_q;
  assign m_address = addr_q;
  assign m_wdata   = wdata_q;
  assign i_resp    = i_resp_q;
  assign d_resp    = d_resp_q;
  assign i_rdata   = buf_q;
  assign d_rdata   = buf_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_scheduler.sv
// Table-driven bench for mem_port_scheduler with a response scoreboard queue.
module tb_mem_port_scheduler;

  logic         clk;
  logic         rst;
  logic         i_read;
  logic [31:0]  i_address;
  logic         i_resp;
  logic [255:0] i_rdata;
  logic         d_read;
  logic         d_write;
  logic [31:0]  d_address;
  logic [255:0] d_wdata;
  logic         d_resp;
  logic [255:0] d_rdata;
  logic         m_read;
  logic         m_write;
  logic [31:0]  m_address;
  logic [255:0] m_wdata;
  logic         m_resp;
  logic [255:0] m_rdata;
  logic         busy;

  int checks;
  int errors;

  typedef struct {
    logic        i_rd;
    logic        d_rd;
    logic        d_wr;
    logic [31:0] i_addr;
    logic [31:0] d_addr;
    logic [7:0]  wpat;
    logic [7:0]  rpat;
    int          lat;
    logic        drop;
    logic        exp_d;
    logic        exp_wr;
    logic [31:0] exp_addr;
  } vec_t;

  typedef struct {
    logic         d_side;
    logic [255:0] rdata;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[5];

  mem_port_scheduler dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_resp(i_resp), .i_rdata(i_rdata),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_resp(d_resp), .d_rdata(d_rdata),
    .m_read(m_read), .m_write(m_write), .m_address(m_address), .m_wdata(m_wdata),
    .m_resp(m_resp), .m_rdata(m_rdata), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic run_txn(input vec_t v);
    exp_t e;
    int   n;
    i_read    = v.i_rd;
    d_read    = v.d_rd;
    d_write   = v.d_wr;
    i_address = v.i_addr;
    d_address = v.d_addr;
    d_wdata   = {32{v.wpat}};
    e.d_side  = v.exp_d;
    e.rdata   = {32{v.rpat}};
    sb.push_back(e);
    n = 0;
    @(negedge clk);
    while (!(m_read || m_write) && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("grant_seen", {255'd0, m_read | m_write}, 256'd1);
    if (v.drop) begin
      i_read    = 1'b0;
      d_read    = 1'b0;
      d_write   = 1'b0;
      i_address = 32'hFFFF_FFC0;
      d_address = 32'hDEAD_BEE0;
      d_wdata   = {256{1'b1}};
    end
    for (int c = 1; c <= v.lat; c++) begin
      chk("m_read",    {255'd0, m_read},  {255'd0, ~v.exp_wr});
      chk("m_write",   {255'd0, m_write}, {255'd0, v.exp_wr});
      chk("m_address", {224'd0, m_address}, {224'd0, v.exp_addr});
      chk("busy_serve", {255'd0, busy}, 256'd1);
      if (v.exp_wr) chk("m_wdata", m_wdata, {32{v.wpat}});
      if (c == v.lat) begin
        m_resp  = 1'b1;
        m_rdata = {32{v.rpat}};
      end
      @(negedge clk);
    end
    m_resp  = 1'b0;
    m_rdata = {8{$urandom}};
    e = sb.pop_front();
    chk("i_resp",  {255'd0, i_resp}, {255'd0, ~e.d_side});
    chk("d_resp",  {255'd0, d_resp}, {255'd0, e.d_side});
    chk("i_rdata", i_rdata, e.rdata);
    chk("d_rdata", d_rdata, e.rdata);
    chk("m_idle_in_resp", {254'd0, m_read, m_write}, 256'd0);
    @(negedge clk);
    chk("resp_pulse_end", {254'd0, i_resp, d_resp}, 256'd0);
    chk("busy_idle", {255'd0, busy}, 256'd0);
  endtask

  initial begin
    vec_t v;
    logic [255:0] keep;
    int n;
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    i_read    = 1'b0;
    d_read    = 1'b0;
    d_write   = 1'b0;
    i_address = 32'd0;
    d_address = 32'd0;
    d_wdata   = 256'd0;
    m_resp    = 1'b0;
    m_rdata   = 256'd0;

    vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h0000_0060, 32'h0, 8'h00, 8'hA5, 1, 1'b1, 1'b0, 1'b0, 32'h0000_0060};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 32'h0, 32'h8000_0020, 8'h3C, 8'h11, 5, 1'b1, 1'b1, 1'b1, 32'h8000_0020};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 32'h0, 32'h0000_0100, 8'h5A, 8'h22, 2, 1'b1, 1'b1, 1'b1, 32'h0000_0100};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_0200, 8'h00, 8'hC3, 3, 1'b1, 1'b1, 1'b0, 32'h0000_0200};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 32'h0000_0300, 32'h0000_0400, 8'h77, 8'h99, 1, 1'b1, 1'b1, 1'b1, 32'h0000_0400};

    repeat (2) @(negedge clk);
    chk("rst_busy",  {255'd0, busy}, 256'd0);
    chk("rst_mreq",  {254'd0, m_read, m_write}, 256'd0);
    chk("rst_resp",  {254'd0, i_resp, d_resp}, 256'd0);
    chk("rst_addr",  {224'd0, m_address}, 256'd0);
    chk("rst_rdata", i_rdata | d_rdata | m_wdata, 256'd0);
    rst = 1'b0;

    for (int k = 0; k < 5; k++) run_txn(vecs[k]);

    // Memory completion while idle must be ignored
    keep    = {32{8'h99}};
    m_resp  = 1'b1;
    m_rdata = {32{8'hEE}};
    @(negedge clk);
    m_resp  = 1'b0;
    @(negedge clk);
    chk("idle_mresp_busy",  {255'd0, busy}, 256'd0);
    chk("idle_mresp_resp",  {254'd0, i_resp, d_resp}, 256'd0);
    chk("idle_mresp_rdata", i_rdata, keep);

    // Reset in the middle of a serve abandons it silently
    i_read    = 1'b1;
    i_address = 32'h0000_0040;
    n = 0;
    @(negedge clk);
    while (!m_read && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("rst_txn_grant", {255'd0, m_read}, 256'd1);
    rst    = 1'b1;
    i_read = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy",  {255'd0, busy}, 256'd0);
    chk("midrst_mread", {255'd0, m_read}, 256'd0);
    chk("midrst_resp",  {254'd0, i_resp, d_resp}, 256'd0);
    chk("midrst_addr",  {224'd0, m_address}, 256'd0);
    chk("midrst_rdata", i_rdata, 256'd0);
    m_resp  = 1'b1;
    m_rdata = {32{8'hAB}};
    @(negedge clk);
    m_resp  = 1'b0;
    @(negedge clk);
    chk("late_mresp_resp",  {254'd0, i_resp, d_resp}, 256'd0);
    chk("late_mresp_busy",  {255'd0, busy}, 256'd0);
    chk("late_mresp_rdata", d_rdata, 256'd0);

    // I and D read held together across three back-to-back grants
    v = '{1'b1, 1'b1, 1'b0, 32'h0000_0500, 32'h0000_0600, 8'h00, 8'h31, 1, 1'b0, 1'b1, 1'b0, 32'h0000_0600};
    run_txn(v);
`ifdef MEM_PORT_SCHED_RR_EN
    v = '{1'b1, 1'b1, 1'b0, 32'h0000_0500, 32'h0000_0600, 8'h00, 8'h32, 2, 1'b0, 1'b0, 1'b0, 32'h0000_0500};
`else
    v = '{1'b1, 1'b1, 1'b0, 32'h0000_0500, 32'h0000_0600, 8'h00, 8'h32, 2, 1'b0, 1'b1, 1'b0, 32'h0000_0600};
`endif
    run_txn(v);
    v = '{1'b1, 1'b1, 1'b0, 32'h0000_0500, 32'h0000_0600, 8'h00, 8'h33, 1, 1'b1, 1'b1, 1'b0, 32'h0000_0600};
    run_txn(v);

    chk("sb_empty", {224'd0, 32'(sb.size())}, 256'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
